iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational ALU, with a start/busy/done handshake.
- Logic, shift, rotate and compare ops complete in one cycle.
- Multiply uses an iterative shift-add engine; divide uses an iterative restoring divider. Both take WIDTH cycles and produce a remainder and a divide-by-zero indication.
- Sits between the register file/accumulator and the control FSM; the controller stalls on busy.

---
 rtl/iter_alu.sv | 239 +++++++++++++++++++++++
 tb/tb_iter_alu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with a start/busy/done handshake, a shift-add multiplier
// and a restoring divider. Define ITER_ALU_FLAGS_EN to add the registered Z/C/N flags.
module iter_alu #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef ITER_ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n
`endif
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4;
    localparam logic [3:0] OP_SHR1 = 4'h5;
    localparam logic [3:0] OP_ROL1 = 4'h6;
    localparam logic [3:0] OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] oneRes;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divFits;

    always_comb begin
        oneRes = '0;
        case (opcode)
            OP_ADD:  oneRes = operand1 + operand2;
            OP_SUB:  oneRes = operand1 - operand2;
            OP_DIV:  oneRes = '1;
            OP_SHL1: oneRes = {operand1[WIDTH-2:0], 1'b0};
            OP_SHR1: oneRes = {1'b0, operand1[WIDTH-1:1]};
            OP_ROL1: oneRes = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
            OP_ROR1: oneRes = {operand1[0], operand1[WIDTH-1:1]};
            OP_AND:  oneRes = operand1 & operand2;
            OP_OR:   oneRes = operand1 | operand2;
            OP_XOR:  oneRes = operand1 ^ operand2;
            OP_NOR:  oneRes = ~(operand1 | operand2);
            OP_NAND: oneRes = ~(operand1 & operand2);
            OP_XNOR: oneRes = ~(operand1 ^ operand2);
            OP_GT:   oneRes = {{(WIDTH-1){1'b0}}, operand1 > operand2};
            OP_EQ:   oneRes = {{(WIDTH-1){1'b0}}, operand1 == operand2};
            default: oneRes = '0;
        endcase
    end

    // {accHi,accLo} is shifted right for MUL (product enters from the top) and left
    // for DIV (partial remainder in accHi, quotient bits enter accLo from the bottom).
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divDiff  = divShift - {1'b0, opB_q};
        divFits  = ~divDiff[WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opB_d    = opB_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        result_d = result_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accHi_d = '0;
                    accLo_d = operand1;
                    opB_d   = operand2;
                    if (opcode == OP_MUL || (opcode == OP_DIV && operand2 != '0)) begin
                        state_d = (opcode == OP_MUL) ? MUL : DIV;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        result_d = oneRes;
                        rem_d    = (opcode == OP_DIV) ? operand1 : '0;
                        dbz_d    = (opcode == OP_DIV);
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                accHi_d = mulSum[WIDTH:1];
                accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                    rem_d    = '0;
                    dbz_d    = 1'b0;
                end
            end
            DIV: begin
                accHi_d = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], divFits};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = {accLo_q[WIDTH-2:0], divFits};
                    rem_d    = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                    dbz_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opB_q    <= '0;
            accHi_q  <= '0;
            accLo_q  <= '0;
            result_q <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opB_q    <= opB_d;
            accHi_q  <= accHi_d;
            accLo_q  <= accLo_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

`ifdef ITER_ALU_FLAGS_EN
    logic           oneCarry;
    logic [WIDTH:0] addWide;
    logic           flagZ_q, flagZ_d;
    logic           flagC_q, flagC_d;
    logic           flagN_q, flagN_d;

    always_comb begin
        addWide  = {1'b0, operand1} + {1'b0, operand2};
        oneCarry = 1'b0;
        case (opcode)
            OP_ADD:           oneCarry = addWide[WIDTH];
            OP_SUB:           oneCarry = operand1 < operand2;
            OP_SHL1, OP_ROL1: oneCarry = operand1[WIDTH-1];
            OP_SHR1, OP_ROR1: oneCarry = operand1[0];
            default:          oneCarry = 1'b0;
        endcase
    end

    // Flags move only on the edges that write result, i.e. when done_d is raised.
    always_comb begin
        flagZ_d = flagZ_q;
        flagC_d = flagC_q;
        flagN_d = flagN_q;
        if (done_d) begin
            flagZ_d = (result_d == '0);
            flagN_d = result_d[WIDTH-1];
            case (state_q)
                MUL:     flagC_d = |mulSum[WIDTH:1];
                DIV:     flagC_d = 1'b0;
                default: flagC_d = oneCarry;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flagZ_q <= 1'b0;
            flagC_q <= 1'b0;
            flagN_q <= 1'b0;
        end else begin
            flagZ_q <= flagZ_d;
            flagC_q <= flagC_d;
            flagN_q <= flagN_d;
        end
    end

    assign flag_z = flagZ_q;
    assign flag_c = flagC_q;
    assign flag_n = flagN_q;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=16): expectations are queued when a request is
// accepted and checked by a monitor on every done pulse, including done timing and busy.
module tb_iter_alu;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef ITER_ALU_FLAGS_EN
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;
`endif

    iter_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef ITER_ALU_FLAGS_EN
        ,
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         dbz;
        logic         fc;
        bit           iter;
        int           acceptEdge;
        int           doneEdge;
    } sbEntry_t;

    sbEntry_t sb[$];
    int vectorCount = 0;
    int missCount   = 0;
    int edgeCount   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic sbEntry_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        sbEntry_t   e;
        logic [2*W-1:0] p;
        logic [W:0]     s;
        e.res = '0; e.rem = '0; e.dbz = 1'b0; e.fc = 1'b0; e.iter = 1'b0;
        e.acceptEdge = 0; e.doneEdge = 0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.fc = s[W]; end
            4'h1: begin e.res = a - b; e.fc = (a < b); end
            4'h2: begin p = (2*W)'(a) * (2*W)'(b); e.res = p[W-1:0]; e.fc = |p[2*W-1:W]; e.iter = 1'b1; end
            4'h3: begin
                if (b == '0) begin e.res = '1; e.rem = a; e.dbz = 1'b1; end
                else begin e.res = a / b; e.rem = a % b; e.iter = 1'b1; end
            end
            4'h4: begin e.res = a << 1; e.fc = a[W-1]; end
            4'h5: begin e.res = a >> 1; e.fc = a[0]; end
            4'h6: begin e.res = {a[W-2:0], a[W-1]}; e.fc = a[W-1]; end
            4'h7: begin e.res = {a[0], a[W-1:1]}; e.fc = a[0]; end
            4'h8: e.res = a & b;
            4'h9: e.res = a | b;
            4'hA: e.res = a ^ b;
            4'hB: e.res = ~(a | b);
            4'hC: e.res = ~(a & b);
            4'hD: e.res = ~(a ^ b);
            4'hE: e.res = (a > b) ? 1 : 0;
            default: e.res = (a == b) ? 1 : 0;
        endcase
        return e;
    endfunction

    // Monitor: busy must be high exactly between accept and done of an iterative op.
    always @(negedge clk) begin : monitor
        sbEntry_t exp;
        logic     expBusy;
        if (reset) begin
            expBusy = 1'b0;
            if (sb.size() != 0)
                expBusy = sb[0].iter && (edgeCount >= sb[0].acceptEdge) && (edgeCount < sb[0].doneEdge);
            checkOutput("busy", 32'(busy), 32'(expBusy));
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("spuriousDone", 32'(done), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("doneEdge", 32'(edgeCount), 32'(exp.doneEdge));
                    checkOutput("result", 32'(result), 32'(exp.res));
                    checkOutput("remainder", 32'(remainder), 32'(exp.rem));
                    checkOutput("divByZero", 32'(div_by_zero), 32'(exp.dbz));
`ifdef ITER_ALU_FLAGS_EN
                    checkOutput("flagZ", 32'(flag_z), 32'(exp.res == '0));
                    checkOutput("flagN", 32'(flag_n), 32'(exp.res[W-1]));
                    checkOutput("flagC", 32'(flag_c), 32'(exp.fc));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit expectAccept);
        sbEntry_t e;
        start = 1'b1; opcode = op; operand1 = a; operand2 = b;
        if (expectAccept) begin
            e = model(op, a, b);
            e.acceptEdge = edgeCount + 1;
            e.doneEdge   = e.acceptEdge + (e.iter ? W : 0);
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sb.size() != 0 && n < W + 4) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("doneTimeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rop;
        reset = 1'b0; start = 1'b0; opcode = '0; operand1 = '0; operand2 = '0;
        #3;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstResult", 32'(result), 32'd0);
        checkOutput("rstRemainder", 32'(remainder), 32'd0);
        checkOutput("rstDbz", 32'(div_by_zero), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        applyStimulus(4'h0, 16'hFFFF, 16'h0001, 1'b1);
        waitIdle();
        applyStimulus(4'h2, 16'd300, 16'd300, 1'b1);
        waitIdle();
        applyStimulus(4'h3, 16'd1000, 16'd7, 1'b1);
        waitIdle();
        applyStimulus(4'h3, 16'h1234, 16'h0000, 1'b1);
        waitIdle();

        applyStimulus(4'h2, 16'd5, 16'd5, 1'b1);
        repeat (2) tick();
        applyStimulus(4'h0, 16'd1, 16'd1, 1'b0);
        waitIdle();

        applyStimulus(4'h2, 16'd5, 16'd5, 1'b1);
        repeat (W) tick();
        checkOutput("doneBeforeB2B", 32'(done), 32'd1);
        applyStimulus(4'h0, 16'd1, 16'd1, 1'b1);
        waitIdle();

        applyStimulus(4'h3, 16'd1000, 16'd7, 1'b1);
        repeat (4) tick();
        checkOutput("busyPreReset", 32'(busy), 32'd1);
        reset = 1'b0;
        sb.delete();
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortResult", 32'(result), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        applyStimulus(4'h7, 16'h0001, 16'h0000, 1'b1);
        waitIdle();

        applyStimulus(4'h8, 16'hF0F0, 16'h3C3C, 1'b1);
        applyStimulus(4'hB, 16'hF0F0, 16'h0F00, 1'b1);
        applyStimulus(4'hE, 16'h8000, 16'h7FFF, 1'b1);
        applyStimulus(4'hF, 16'hA5A5, 16'hA5A5, 1'b1);
        applyStimulus(4'h1, 16'h0003, 16'h0005, 1'b1);
        applyStimulus(4'h6, 16'h8001, 16'h0000, 1'b1);
        waitIdle();

        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 15));
            applyStimulus(rop, 16'($urandom), (i % 6 == 0) ? 16'h0000 : 16'($urandom), 1'b1);
            waitIdle();
        end

        repeat (3) tick();
        checkOutput("sbDrained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
